// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//
// Contents:
//   WIDTH_DEFAULT    default operand/result width
//   ALU_MULT/ALU_DIV processor ALU opcodes that generate the start pulses
//   INT_MIN          most negative 32-bit two's complement value
//   md_state_e       unit state encoding (idle, multiply, divide, done)
package multdiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv,
        StDone
    } md_state_e;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide unit.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_clear  restart the count at zero (new operation)
//   i_step   one datapath iteration happens this cycle
//   o_last   this step is the final (WIDTH-th) iteration
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_step,
    output logic o_last
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] EndCnt  = CNT_W'(WIDTH);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_step && (r_count != EndCnt)) begin
            // Saturates at WIDTH so a stray step can never wrap mid-operation.
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_last = i_step && (r_count == LastCnt);

endmodule

// File: rtl/multdiv_unit.sv
// Sequential signed multiply/divide responder, one bit per clock.
// Multiply is shift-add over a sign-extended multiplicand; divide is
// non-restoring on magnitudes with a final sign fix-up.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-low reset
//   data_operandA   multiplicand / dividend, sampled on a start edge
//   data_operandB   multiplier / divisor, sampled on a start edge
//   ctrl_MULT       start multiply (wins over ctrl_DIV)
//   ctrl_DIV        start divide
//   data_result     low half of product, or quotient
//   data_exception  overflow or divide-by-zero for the held result
//   data_remainder  signed remainder (only with MULTDIV_REMAINDER_EN)
//   data_resultRDY  one-cycle completion pulse, WIDTH cycles after start
//
// Build option: define MULTDIV_REMAINDER_EN to add data_remainder.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
`ifdef MULTDIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] AllOnes = '1;

    md_state_e r_state, w_state_d;

    logic w_start, w_step, w_last;

    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH+1:0]   r_prem;
    logic [WIDTH-1:0]   r_quo, r_dvsr;
    logic               r_neg_q, r_neg_r, r_div_zero, r_div_ovf;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc, r_rdy;

    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_hi;
    logic               w_mult_exc;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH+1:0]   w_dvsr_ext, w_prem_shift, w_prem_next;
    logic [WIDTH-1:0]   w_quo_next, w_rem_mag;
    logic [WIDTH-1:0]   w_div_result, w_div_rem;
    logic               w_div_exc;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_step  = !w_start && ((r_state == StMult) || (r_state == StDiv));

    multdiv_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clear (w_start),
        .i_step  (w_step),
        .o_last  (w_last)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (ctrl_MULT) begin
            w_state_d = StMult;
        end else if (ctrl_DIV) begin
            w_state_d = StDiv;
        end else begin
            unique case (r_state)
                StMult, StDiv: if (w_last) w_state_d = StDone;
                StDone:        w_state_d = StIdle;
                default:       w_state_d = r_state;
            endcase
        end
    end

    // Multiplier bit WIDTH-1 carries negative weight, so the last step subtracts.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = w_last ? (r_acc - r_mcand) : (r_acc + r_mcand);
        end
    end

    assign w_hi       = w_acc_next[2*WIDTH-1:WIDTH-1];
    assign w_mult_exc = !((&w_hi) || !(|w_hi));

    assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Non-restoring step: partial remainder stays in [-D, D), so WIDTH+2 bits suffice.
    assign w_dvsr_ext   = {2'b00, r_dvsr};
    assign w_prem_shift = {r_prem[WIDTH:0], r_quo[WIDTH-1]};
    assign w_prem_next  = r_prem[WIDTH+1] ? (w_prem_shift + w_dvsr_ext)
                                          : (w_prem_shift - w_dvsr_ext);
    assign w_quo_next   = {r_quo[WIDTH-2:0], ~w_prem_next[WIDTH+1]};
    assign w_rem_mag    = w_prem_next[WIDTH+1] ? (w_prem_next[WIDTH-1:0] + r_dvsr)
                                               : w_prem_next[WIDTH-1:0];

    always_comb begin
        w_div_result = r_neg_q ? -w_quo_next : w_quo_next;
        w_div_rem    = r_neg_r ? -w_rem_mag : w_rem_mag;
        w_div_exc    = 1'b0;
        if (r_div_zero) begin
            w_div_result = '0;
            w_div_rem    = '0;
            w_div_exc    = 1'b1;
        end else if (r_div_ovf) begin
            w_div_result = MinVal;
            w_div_rem    = '0;
            w_div_exc    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prem     <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_MULT) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                r_mplier <= data_operandB;
            end else if (ctrl_DIV) begin
                r_prem     <= '0;
                r_quo      <= w_mag_a;
                r_dvsr     <= w_mag_b;
                r_neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_neg_r    <= data_operandA[WIDTH-1];
                r_div_zero <= (data_operandB == '0);
                r_div_ovf  <= (data_operandA == MinVal) && (data_operandB == AllOnes);
            end else if (r_state == StMult) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (w_last) begin
                    r_result <= w_acc_next[WIDTH-1:0];
                    r_exc    <= w_mult_exc;
                    r_rdy    <= 1'b1;
                end
            end else if (r_state == StDiv) begin
                r_prem <= w_prem_next;
                r_quo  <= w_quo_next;
                if (w_last) begin
                    r_result <= w_div_result;
                    r_exc    <= w_div_exc;
                    r_rdy    <= 1'b1;
                end
            end
        end
    end

`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] r_rem_out;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rem_out <= '0;
        end else if (w_last) begin
            r_rem_out <= (r_state == StDiv) ? w_div_rem : '0;
        end
    end

    assign data_remainder = r_rem_out;
`else
    logic w_unused_rem;
    assign w_unused_rem = ^w_div_rem;
`endif

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized
// back-to-back operations against a 64-bit arithmetic reference model.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef MULTDIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prev_res = '0;
    logic        prev_exc = 1'b0;

    multdiv_unit #(
        .WIDTH(32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
`ifdef MULTDIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic.
    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc,
                                  output logic [31:0] rem);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rem = '0;
        if (m) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p != longint'($signed(p[31:0])));
        end else if (sb == 0) begin
            res = '0;
            exc = 1'b1;
        end else if (sa == -longint'(64'd2147483648) && sb == -1) begin
            res = INT_MIN;
            exc = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = q[31:0];
            rem = r[31:0];
            exc = 1'b0;
        end
    endfunction

    // Called at a negedge; the start edge is the next posedge. Returns one negedge later.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_result(input string tag, input bit m, input logic [31:0] a,
                               input logic [31:0] b);
        logic [31:0] er, erem;
        logic        ee;
        int          lat;
        model(m, a, b, er, ee, erem);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (n == 16) begin
                check_eq({tag, "_hold_res"}, 64'(data_result), 64'(prev_res));
                check_eq({tag, "_hold_exc"}, 64'(data_exception), 64'(prev_exc));
            end
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd32);
        if (lat != 0) begin
            check_eq({tag, "_res"}, 64'(data_result), 64'(er));
            check_eq({tag, "_exc"}, 64'(data_exception), 64'(ee));
`ifdef MULTDIV_REMAINDER_EN
            check_eq({tag, "_rem"}, 64'(data_remainder), 64'(erem));
`endif
            prev_res = er;
            prev_exc = ee;
        end
    endtask

    task automatic run_op(input string tag, input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b);
        start_op(m, d, a, b);
        wait_result(tag, m, a, b);
    endtask

    task automatic pulse_width(input string tag);
        @(negedge clock);
        check_eq({tag, "_rdy_width"}, 64'(data_resultRDY), 64'd0);
    endtask

    task automatic no_rdy_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check_eq({tag, "_no_rdy"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit          m;

        repeat (3) @(negedge clock);
        check_eq("reset_res", 64'(data_result), 64'd0);
        check_eq("reset_exc", 64'(data_exception), 64'd0);
        check_eq("reset_rdy", 64'(data_resultRDY), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("idle_rdy", 64'(data_resultRDY), 64'd0);

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        pulse_width("mul_7_m3");
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        pulse_width("div_m7_2");
        run_op("div_min_m1", 1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF);
        run_op("div_by0", 1'b0, 1'b1, 32'd5, 32'd0);
        run_op("both_high", 1'b1, 1'b1, 32'd6, 32'd7);

        // Abort a multiply with a divide ten cycles later.
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        no_rdy_for("abort", 9);
        run_op("restart_div", 1'b0, 1'b1, 32'd100, 32'd7);

        // Randomized, back-to-back: each start after the first lands in DONE.
        for (int t = 0; t < 50; t++) begin
            m = 1'(($urandom & 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                1: begin a = 32'($signed($urandom_range(0, 200)) - 100);
                         b = 32'($signed($urandom_range(0, 200)) - 100); end
                2: b = '0;
                3: begin b = 32'hFFFF_FFFF; if ($urandom & 1) a = INT_MIN; end
                4: a = INT_MIN;
                5: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", t), m, !m, a, b);
        end
        pulse_width("rnd_last");

        // Reset partway through a multiply.
        run_op("pre_reset", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_eq("midreset_res", 64'(data_result), 64'd0);
        check_eq("midreset_exc", 64'(data_exception), 64'd0);
        check_eq("midreset_rdy", 64'(data_resultRDY), 64'd0);
`ifdef MULTDIV_REMAINDER_EN
        check_eq("midreset_rem", 64'(data_remainder), 64'd0);
`endif
        no_rdy_for("midreset", 40);
        prev_res = '0;
        prev_exc = 1'b0;

        // Reset and start together: reset wins, nothing runs.
        reset         = 1'b0;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        reset     = 1'b1;
        ctrl_MULT = 1'b0;
        no_rdy_for("reset_start", 40);
        check_eq("reset_start_res", 64'(data_result), 64'd0);

        run_op("post_reset", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
